// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul -- iterative 32x32 shift-and-add multiplier for the
// RV32M MUL / MULH / MULHSU / MULHU operations, placed in EX beside the ALU.
//
// The operands are converted to magnitudes when they are latched. Each CALC
// cycle adds the multiplicand into the high word when the current multiplier
// bit is 1, then shifts the 65-bit {carry,hi,lo} value right by one. FIX
// applies the result sign and DONE presents the selected word.
//
// Optional build macro: SEQ_MUL_EARLY_OUT_EN
//   When defined, CALC detects that every remaining multiplier bit is zero.
//   It then applies all of the remaining shifts at once and moves to FIX.
//   Results are unchanged and latency becomes 3 + iterations performed.
//   When undefined, latency is a fixed 34 cycles and there is no zero-detect.
//
// Ports:
//   i_clk        clock; all state changes on the rising edge
//   i_rst        synchronous, active-high reset
//   i_start      multiply request; sampled only while idle
//   i_op         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_rs1        multiplicand
//   i_rs2        multiplier
//   o_busy       high while a multiply is in flight (state != IDLE)
//   o_valid      one-cycle pulse; o_result is valid in that cycle
//   o_result     selected product word; holds until the next o_valid
//   o_dbg_state  current FSM state (0 IDLE, 1 CALC, 2 FIX, 3 DONE)
//
// Handshake with the hazard unit: i_start is accepted only when o_busy is
// low. It is sampled on the rising edge, and o_busy rises in the next cycle.
// A request made while o_busy is high is dropped, not queued. Operands and
// op are captured at acceptance, so later changes to i_op/i_rs* are ignored.
// o_valid pulses for exactly one cycle per accepted request that is not
// cancelled by reset. o_busy falls in the cycle after o_valid, and a new
// i_start may be given in that same cycle.

module seq_shift_add_mul_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module seq_shift_add_mul #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic            o_busy,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result,
   output logic [1:0]      o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [1:0]        OP_MUL    = 2'b00;
   localparam logic [1:0]        OP_MULH   = 2'b01;
   localparam logic [1:0]        OP_MULHSU = 2'b10;
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]   ONE       = XLEN'(1);
   localparam logic [2*XLEN-1:0] ONE2      = (2*XLEN)'(1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   hi, lo, mcand;
   logic              neg;
   logic [1:0]        op;

   // ---------------- operand conditioning (used only in IDLE) --------------
   logic            rs1_signed, rs2_signed;
   logic            rs1_neg, rs2_neg;
   logic [XLEN-1:0] rs1_mag, rs2_mag;

   assign rs1_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU);
   assign rs2_signed = (i_op == OP_MULH);
   assign rs1_neg    = rs1_signed & i_rs1[XLEN-1];
   assign rs2_neg    = rs2_signed & i_rs2[XLEN-1];
   // The magnitude of the most negative value wraps to 0x80000000, which is
   // correct when it is read as unsigned.
   assign rs1_mag    = rs1_neg ? (~i_rs1 + ONE) : i_rs1;
   assign rs2_mag    = rs2_neg ? (~i_rs2 + ONE) : i_rs2;

   // ---------------- 33-bit ripple-carry accumulate --------------------------
   // Bit 32 of both addends is always zero, so the top position of the chain
   // reduces to the carry out of bit 31. That carry becomes sum[XLEN].
   logic [XLEN-1:0] add_b;
   logic [XLEN:0]   carry;
   logic [XLEN:0]   sum;

   assign add_b    = lo[0] ? mcand : '0;
   assign carry[0] = 1'b0;

   for (genvar g = 0; g < XLEN; g++) begin : g_fa
      seq_shift_add_mul_fa u_fa (
         .a  (hi[g]),
         .b  (add_b[g]),
         .ci (carry[g]),
         .s  (sum[g]),
         .co (carry[g+1])
      );
   end
   assign sum[XLEN] = carry[XLEN];

   // ---------------- sign fix-up --------------------------------------------
   logic [2*XLEN-1:0] prod_fix;
   assign prod_fix = neg ? (~{hi, lo} + ONE2) : {hi, lo};

`ifdef SEQ_MUL_EARLY_OUT_EN
   // lo[XLEN-1-cnt:0] still holds the multiplier bits that have not been
   // consumed. If they are all zero, each remaining step is a pure shift.
   localparam logic [XLEN-1:0] ONES   = '1;
   localparam logic [CNT_W:0]  N_ITER = (CNT_W+1)'(XLEN);
   logic           early_out;
   logic [CNT_W:0] skip_amt;
   assign early_out = ((lo & (ONES >> cnt)) == '0);
   assign skip_amt  = N_ITER - {1'b0, cnt};
`endif

   // ---------------- FSM: state register -----------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // ---------------- FSM: next state and outputs ----------------------------
   always_comb begin
      state_nxt   = state;
      o_busy      = (state != S_IDLE);
      o_valid     = 1'b0;
      o_dbg_state = state;
      case (state)
         S_IDLE: if (i_start) state_nxt = S_CALC;
         S_CALC: begin
`ifdef SEQ_MUL_EARLY_OUT_EN
            if (early_out || (cnt == LAST_CNT)) state_nxt = S_FIX;
`else
            if (cnt == LAST_CNT) state_nxt = S_FIX;
`endif
         end
         S_FIX:  state_nxt = S_DONE;
         S_DONE: begin
            o_valid   = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- datapath ----------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         mcand    <= '0;
         neg      <= 1'b0;
         op       <= OP_MUL;
         o_result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  mcand <= rs1_mag;
                  hi    <= '0;
                  lo    <= rs2_mag;
                  cnt   <= '0;
                  neg   <= rs1_neg ^ rs2_neg;
                  op    <= i_op;
               end
            end
            S_CALC: begin
`ifdef SEQ_MUL_EARLY_OUT_EN
               if (early_out) begin
                  {hi, lo} <= {hi, lo} >> skip_amt;
               end else begin
                  {hi, lo} <= {sum, lo[XLEN-1:1]};
                  cnt      <= cnt + CNT_W'(1);
               end
`else
               {hi, lo} <= {sum, lo[XLEN-1:1]};
               cnt      <= cnt + CNT_W'(1);
`endif
            end
            S_FIX: begin
               {hi, lo} <= prod_fix;
               // Latch the output word here so it stays stable after DONE.
               o_result <= (op == OP_MUL) ? prod_fix[XLEN-1:0]
                                          : prod_fix[2*XLEN-1:XLEN];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench for seq_shift_add_mul. It runs directed corner cases
// and then 1000 randomized multiplies. Results and latency are compared with
// a 64-bit arithmetic reference model. Optional macro: SEQ_MUL_EARLY_OUT_EN,
// which selects the variable-latency expectation.

module tb_seq_shift_add_mul;

   logic        i_clk, i_rst, i_start;
   logic [1:0]  i_op;
   logic [31:0] i_rs1, i_rs2;
   logic        o_busy, o_valid;
   logic [31:0] o_result;
   logic [1:0]  o_dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   longint      cyc = 0;
   int          valid_cnt = 0;
   longint      last_valid_cyc = 0;
   longint      prev_valid_cyc = 0;
   logic [31:0] exp_q[$];

   seq_shift_add_mul u_dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_op        (i_op),
      .i_rs1       (i_rs1),
      .i_rs2       (i_rs2),
      .o_busy      (o_busy),
      .o_valid     (o_valid),
      .o_result    (o_result),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- clock / reset / monitors ------------------------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc++;
   always @(negedge i_clk) if (o_valid) valid_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checker -----------------------------------------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ---------------------------------------
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      eb = (op == 2'b01)                ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // Start-to-valid distance in cycles.
   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef SEQ_MUL_EARLY_OUT_EN
      logic [31:0] m;
      int          bl;
      m  = (op == 2'b01 && b[31]) ? -b : b;
      bl = 0;
      for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
      return (3 + bl > 34) ? 34 : 3 + bl;
`else
      return 34;
`endif
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- driver ------------------------------------------------
   // Called at a falling edge while idle. The task returns at the falling
   // edge of the first idle cycle after o_valid. While the multiply is in
   // flight, operands are scrambled every cycle. An extra start pulse is
   // issued at cycle poke_at (0 = never).
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input int poke_at);
      int          lat;
      logic        busy_ok;
      logic [31:0] got, exp;
      exp_q.push_back(ref_mul(op, a, b));
      i_start = 1'b1;
      i_op    = op;
      i_rs1   = a;
      i_rs2   = b;
      @(posedge i_clk);
      lat     = 0;
      busy_ok = 1'b1;
      got     = '0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge i_clk);
         i_start = (k == poke_at);
         i_op    = 2'($urandom);
         i_rs1   = $urandom;
         i_rs2   = $urandom;
         if (!o_busy) busy_ok = 1'b0;
         if (o_valid) begin
            lat            = k;
            got            = o_result;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            break;
         end
      end
      exp = exp_q.pop_front();
      check_eq({tag, " valid_seen"}, 64'(lat != 0), 64'(1));
      check_eq({tag, " result"}, got, exp);
      check_eq({tag, " latency"}, lat, ref_lat(op, b));
      check_eq({tag, " busy_during"}, busy_ok, 1'b1);
      i_start = 1'b0;
      @(negedge i_clk);
      check_eq({tag, " valid_width"}, o_valid, 1'b0);
      check_eq({tag, " busy_after"}, o_busy, 1'b0);
   endtask

   // ---------------- stimulus ----------------------------------------------
   initial begin
      int          snap;
      int          rst_at;
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;

      i_rst   = 1'b1;
      i_start = 1'b0;
      i_op    = 2'b00;
      i_rs1   = '0;
      i_rs2   = '0;
      repeat (3) @(negedge i_clk);
      check_eq("reset busy", o_busy, 1'b0);
      check_eq("reset valid", o_valid, 1'b0);
      check_eq("reset result", o_result, 32'h0);
      i_rst = 1'b0;
      @(negedge i_clk);

      // Directed values
      run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, "mul_7_m3", 0);
      check_eq("mul_7_m3 const", o_result, 32'hFFFF_FFEB);
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mulh_min", 0);
      check_eq("mulh_min const", o_result, 32'h4000_0000);
      run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1", 0);
      check_eq("mulhsu_m1 const", o_result, 32'hFFFF_FFFF);
      run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max", 0);
      check_eq("mulhu_max const", o_result, 32'hFFFF_FFFE);
      run_op(2'b11, 32'h1234_5678, 32'h0000_0000, "mulhu_zero", 0);
      run_op(2'b00, 32'h0000_0009, 32'h0000_0001, "mul_9_1", 0);
      run_op(2'b01, 32'hFFFF_FFFB, 32'h0000_0000, "mulh_negzero", 0);
      run_op(2'b00, 32'h0000_0000, 32'hFFFF_FFFD, "mul_zero_a", 0);

      // A start during busy must be ignored.
      snap = valid_cnt;
      run_op(2'b00, 32'd3, 32'd4, "poke", 5);
      repeat (40) @(negedge i_clk);
      check_eq("poke extra_valid", valid_cnt, snap + 1);
      check_eq("poke busy_idle", o_busy, 1'b0);

      // Back-to-back: the second start comes in the single idle cycle.
      run_op(2'b00, 32'd2, 32'd3, "b2b_first", 0);
      run_op(2'b00, 32'd10, 32'd10, "b2b_second", 0);
      check_eq("b2b gap", last_valid_cyc - prev_valid_cyc, 64'(1 + ref_lat(2'b00, 32'd10)));
      check_eq("b2b const", o_result, 32'd100);

      // Reset mid-run: the run is dropped and o_result clears.
`ifdef SEQ_MUL_EARLY_OUT_EN
      rst_at = 2;
`else
      rst_at = 10;
`endif
      snap    = valid_cnt;
      i_start = 1'b1;
      i_op    = 2'b11;
      i_rs1   = 32'd5;
      i_rs2   = 32'd7;
      @(posedge i_clk);
      for (int k = 1; k <= rst_at; k++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         if (k == rst_at) i_rst = 1'b1;
      end
      @(negedge i_clk);
      i_rst = 1'b0;
      check_eq("midrst busy", o_busy, 1'b0);
      check_eq("midrst valid", o_valid, 1'b0);
      check_eq("midrst result", o_result, 32'h0);
      repeat (45) @(negedge i_clk);
      check_eq("midrst no_valid", valid_cnt, snap);

      // Randomized runs
      for (int n = 0; n < 1000; n++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = pick_operand();
         r_b  = pick_operand();
         repeat ($urandom_range(0, 2)) @(negedge i_clk);
         run_op(r_op, r_a, r_b, "rand", 0);
      end

      check_eq("scoreboard drained", 64'(exp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
